// File: rtl/key_entry_ctrl_if.sv
// Keypad-side strobes and transmitter-side frame handshake of key_entry_ctrl.
// master drives keys and frame_ready; slave (the controller) returns the frame and status.
interface key_entry_ctrl_if #(
    parameter int unsigned DEPTH = 4
);
    logic [3:0]         key_code;
    logic               key_valid;
    logic               frame_valid;
    logic               frame_ready;
    logic [4*DEPTH-1:0] frame_data;
    logic [3:0]         frame_len;
    logic               busy;
    logic               overflow;
    logic               timeout;

    modport master (
        output key_code, key_valid, frame_ready,
        input  frame_valid, frame_data, frame_len, busy, overflow, timeout
    );

    modport slave (
        input  key_code, key_valid, frame_ready,
        output frame_valid, frame_data, frame_len, busy, overflow, timeout
    );
endinterface

// File: rtl/key_entry_ctrl.sv
// Keypad entry sequencer: assembles digits, handles backspace/clear/enter,
// offers the finished entry over valid/ready and drops stale partial entries.
module key_entry_ctrl #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 50000
) (
    input logic             clk_10k,
    input logic             rst_n,
    key_entry_ctrl_if.slave bus
);
    localparam int unsigned DW = 4 * DEPTH;
    localparam int unsigned CW = 20;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ENTRY = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;

    localparam logic [3:0] K_BACK  = 4'hA;
    localparam logic [3:0] K_CLEAR = 4'hB;
    localparam logic [3:0] K_ENTER = 4'hF;

    localparam logic [3:0]    LEN_MAX = 4'(DEPTH);
    localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] data_q,  data_d;
    logic [3:0]    len_q,   len_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          valid_q, valid_d;
    logic          ovf_q,   ovf_d;
    logic          tmo_q,   tmo_d;
    logic          is_digit_c;
    logic          accepted_c;

    // Codes C..E are not accepted keys: they neither act nor restart the timer.
    always_comb begin
        is_digit_c = (bus.key_code <= 4'd9);
        accepted_c = bus.key_valid &&
                     (is_digit_c || bus.key_code == K_BACK ||
                      bus.key_code == K_CLEAR || bus.key_code == K_ENTER);
    end

    always_ff @(posedge clk_10k) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ovf_d   = 1'b0;
        tmo_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accepted_c) begin
                    if (is_digit_c) begin
                        data_d  = (data_q << 4) | DW'(bus.key_code);
                        len_d   = 4'd1;
                        state_d = S_ENTRY;
                    end else if (bus.key_code == K_CLEAR) begin
                        data_d = '0;
                        len_d  = '0;
                    end
                end
            end

            S_ENTRY: begin
                if (accepted_c) begin
                    cnt_d = '0;
                    if (is_digit_c) begin
                        if (len_q == LEN_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            data_d = (data_q << 4) | DW'(bus.key_code);
                            len_d  = len_q + 4'd1;
                        end
                    end else if (bus.key_code == K_BACK) begin
                        data_d = data_q >> 4;
                        len_d  = len_q - 4'd1;
                        if (len_q == 4'd1) begin
                            state_d = S_IDLE;
                        end
                    end else if (bus.key_code == K_CLEAR) begin
                        data_d  = '0;
                        len_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SEND;
                    end
                end else if (cnt_q == CNT_LIM) begin
                    // Stale partial entry: discard and report.
                    data_d  = '0;
                    len_d   = '0;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_SEND: begin
                cnt_d = '0;
                if (bus.frame_ready) begin
                    data_d  = '0;
                    len_d   = '0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                data_d  = '0;
                len_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        valid_d = (state_d == S_SEND);
    end

    assign bus.frame_valid = valid_q;
    assign bus.busy        = valid_q;
    assign bus.frame_data  = data_q;
    assign bus.frame_len   = len_q;
    assign bus.overflow    = ovf_q;
    assign bus.timeout     = tmo_q;
endmodule

// File: tb/tb_key_entry_ctrl.sv
// Table-driven bench for key_entry_ctrl: each row is one clock of stimulus plus
// the outputs expected after that edge, queued at drive time and checked after the edge.
module tb_key_entry_ctrl;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 8;

    typedef struct {
        logic        rst_n;
        logic        kv;
        logic [3:0]  kc;
        logic        rdy;
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  el;
        logic        eo;
        logic        et;
    } vec_t;

    logic clk_10k = 1'b0;
    logic rst_n;

    key_entry_ctrl_if #(.DEPTH(DEPTH)) bus ();

    key_entry_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_10k (clk_10k),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_10k = ~clk_10k;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   hs_cnt = 0;

    function automatic void r(input logic rn, input logic kv, input logic [3:0] kc,
                              input logic rdy, input logic ev, input logic [15:0] ed,
                              input logic [3:0] el, input logic eo = 1'b0,
                              input logic et = 1'b0);
        vec_t v;
        v.rst_n = rn; v.kv = kv; v.kc = kc; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.el = el; v.eo = eo; v.et = et;
        vecs.push_back(v);
    endfunction

    function automatic void k(input logic [3:0] kc, input logic rdy, input logic ev,
                              input logic [15:0] ed, input logic [3:0] el,
                              input logic eo = 1'b0, input logic et = 1'b0);
        r(1'b1, 1'b1, kc, rdy, ev, ed, el, eo, et);
    endfunction

    function automatic void n(input logic rdy, input logic ev, input logic [15:0] ed,
                              input logic [3:0] el, input logic eo = 1'b0,
                              input logic et = 1'b0);
        r(1'b1, 1'b0, 4'h0, rdy, ev, ed, el, eo, et);
    endfunction

    task automatic check_row(input int idx, input vec_t e);
        checks++;
        if (bus.frame_valid !== e.ev || bus.busy !== e.ev || bus.frame_data !== e.ed ||
            bus.frame_len !== e.el || bus.overflow !== e.eo || bus.timeout !== e.et) begin
            errors++;
            $display("FAIL row%0d outputs: got v=%b b=%b d=%h l=%0d o=%b t=%b, want v=%b b=%b d=%h l=%0d o=%b t=%b",
                     idx, bus.frame_valid, bus.busy, bus.frame_data, bus.frame_len,
                     bus.overflow, bus.timeout, e.ev, e.ev, e.ed, e.el, e.eo, e.et);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        rst_n         = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.frame_ready = 1'b0;

        // Reset, then 1,2,3, enter with frame_ready held: one-cycle frame 0x123.
        r(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0, 4'd0);
        k(4'h1, 1'b1, 1'b0, 16'h0001, 4'd1);
        k(4'h2, 1'b1, 1'b0, 16'h0012, 4'd2);
        k(4'h3, 1'b1, 1'b0, 16'h0123, 4'd3);
        k(4'hF, 1'b1, 1'b1, 16'h0123, 4'd3);
        n(1'b1, 1'b0, 16'h0, 4'd0);
        n(1'b0, 1'b0, 16'h0, 4'd0);

        // Fill past DEPTH: fifth digit overflows, single-cycle pulse.
        k(4'h9, 1'b0, 1'b0, 16'h0009, 4'd1);
        k(4'h8, 1'b0, 1'b0, 16'h0098, 4'd2);
        k(4'h7, 1'b0, 1'b0, 16'h0987, 4'd3);
        k(4'h6, 1'b0, 1'b0, 16'h9876, 4'd4);
        k(4'h5, 1'b0, 1'b0, 16'h9876, 4'd4, 1'b1);
        n(1'b0, 1'b0, 16'h9876, 4'd4);
        k(4'hB, 1'b0, 1'b0, 16'h0, 4'd0);

        // Backspace down to empty and past it; enter in IDLE is ignored.
        k(4'h4, 1'b0, 1'b0, 16'h0004, 4'd1);
        k(4'h5, 1'b0, 1'b0, 16'h0045, 4'd2);
        k(4'hA, 1'b0, 1'b0, 16'h0004, 4'd1);
        k(4'hA, 1'b0, 1'b0, 16'h0, 4'd0);
        k(4'hA, 1'b0, 1'b0, 16'h0, 4'd0);
        k(4'hF, 1'b0, 1'b0, 16'h0, 4'd0);
        n(1'b0, 1'b0, 16'h0, 4'd0);

        // Stalled SEND: keys dropped; a key on the handshake edge is dropped too.
        k(4'h1, 1'b0, 1'b0, 16'h0001, 4'd1);
        k(4'hF, 1'b0, 1'b1, 16'h0001, 4'd1);
        for (int c = 1; c <= 10; c++) begin
            if (c == 2)      k(4'h2, 1'b0, 1'b1, 16'h0001, 4'd1);
            else if (c == 5) k(4'h3, 1'b0, 1'b1, 16'h0001, 4'd1);
            else             n(1'b0, 1'b1, 16'h0001, 4'd1);
        end
        k(4'h5, 1'b1, 1'b0, 16'h0, 4'd0);
        n(1'b0, 1'b0, 16'h0, 4'd0);

        // Timeout 8 cycles after the last accepted key.
        k(4'h7, 1'b0, 1'b0, 16'h0007, 4'd1);
        for (int c = 1; c <= 7; c++) n(1'b0, 1'b0, 16'h0007, 4'd1);
        n(1'b0, 1'b0, 16'h0, 4'd0, 1'b0, 1'b1);
        n(1'b0, 1'b0, 16'h0, 4'd0);

        // Ignored code C does not restart the timer.
        k(4'h7, 1'b0, 1'b0, 16'h0007, 4'd1);
        for (int c = 1; c <= 7; c++) begin
            if (c == 5) k(4'hC, 1'b0, 1'b0, 16'h0007, 4'd1);
            else        n(1'b0, 1'b0, 16'h0007, 4'd1);
        end
        n(1'b0, 1'b0, 16'h0, 4'd0, 1'b0, 1'b1);
        n(1'b0, 1'b0, 16'h0, 4'd0);

        // A digit at cycle 5 pushes the timeout out to cycle 13.
        k(4'h7, 1'b0, 1'b0, 16'h0007, 4'd1);
        for (int c = 1; c <= 4; c++) n(1'b0, 1'b0, 16'h0007, 4'd1);
        k(4'h3, 1'b0, 1'b0, 16'h0073, 4'd2);
        for (int c = 6; c <= 12; c++) n(1'b0, 1'b0, 16'h0073, 4'd2);
        n(1'b0, 1'b0, 16'h0, 4'd0, 1'b0, 1'b1);
        n(1'b0, 1'b0, 16'h0, 4'd0);

        // Reset in the middle of SEND, then normal operation resumes.
        k(4'h1, 1'b0, 1'b0, 16'h0001, 4'd1);
        k(4'h2, 1'b0, 1'b0, 16'h0012, 4'd2);
        k(4'hF, 1'b0, 1'b1, 16'h0012, 4'd2);
        n(1'b0, 1'b1, 16'h0012, 4'd2);
        r(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0, 4'd0);
        n(1'b0, 1'b0, 16'h0, 4'd0);
        k(4'h6, 1'b0, 1'b0, 16'h0006, 4'd1);
        k(4'hB, 1'b0, 1'b0, 16'h0, 4'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n           = vecs[i].rst_n;
            bus.key_valid   = vecs[i].kv;
            bus.key_code    = vecs[i].kc;
            bus.frame_ready = vecs[i].rdy;
            exp_q.push_back(vecs[i]);
            if (rst_n && bus.frame_valid && bus.frame_ready) hs_cnt++;
            @(posedge clk_10k);
            #1;
            e = exp_q.pop_front();
            check_row(i, e);
        end

        checks++;
        if (hs_cnt != 2) begin
            errors++;
            $display("FAIL handshake_count: got %0d, want 2", hs_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_entry_ctrl.md
# key_entry_ctrl

Sequencer between the 4x4 keypad scanner and the link transmitter. It consumes one-cycle key strobes, assembles up to DEPTH decimal digits into a packed entry buffer, and handles backspace, clear and enter keys. On enter it hands the completed entry to the transmitter over a valid/ready handshake. An inactivity timeout discards stale partial entries.

## Interface
- DEPTH, 4: maximum digits per entry; legal range 1..8.
- TIMEOUT, 50000: inactivity limit in clk_10k cycles (5 s at 10 kHz); legal range 2..2^20-1.
- clk_10k  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- key_code  in  4  key code from the scanner; sampled only when key_valid=1.
- key_valid  in  1  one-cycle strobe per key press.
- frame_valid  out  1  entry offered to the transmitter.
- frame_ready  in  1  transmitter accepts the entry.
- frame_data  out  4*DEPTH  packed digits; newest digit in [3:0]; unused nibbles 0.
- frame_len  out  4  number of valid digits, 0..DEPTH.
- busy  out  1  high in SEND; key strobes are ignored.
- overflow  out  1  one-cycle pulse: digit rejected because the buffer is full.
- timeout  out  1  one-cycle pulse: partial entry discarded after inactivity.

## Operation
- Key map:
  - 4'h0..4'h9 = digit.
  - 4'hA = backspace.
  - 4'hB = clear.
  - 4'hF = enter.
  - 4'hC, 4'hD, 4'hE are ignored: no state change, and the timer is not restarted.
- States:
  - IDLE: len=0.
  - ENTRY: 1 <= len <= DEPTH.
  - SEND: frame_valid=1.
- Digit, len<DEPTH:
  - frame_data <= {frame_data[4*DEPTH-5:0], digit}.
  - len+1.
  - IDLE->ENTRY.
- Digit, len=DEPTH:
  - Buffer unchanged; overflow pulses next cycle.
  - The timer still restarts.
- Backspace in ENTRY:
  - frame_data <= frame_data >> 4 (zero fill); len-1.
  - ENTRY->IDLE if len becomes 0.
  - In IDLE: no effect.
- Clear: data=0, len=0, state IDLE (from IDLE or ENTRY).
- Enter:
  - In ENTRY: state SEND; data and len frozen.
  - In IDLE: ignored; an empty frame is never sent.
- SEND:
  - frame_valid=1, busy=1; all key strobes are dropped (not queued).
  - On a clock edge with frame_ready=1: data=0, len=0, state IDLE.
- Timeout:
  - An 20-bit idle counter clears on every accepted key (digit, backspace, clear, enter, overflowed digit).
  - It counts in ENTRY only and is held at 0 in IDLE and SEND.
  - When the counter reaches TIMEOUT-1 in ENTRY, with no key_valid that cycle: clear buffer, go to IDLE, pulse timeout.
  - A key on the same cycle wins: it is processed normally and the counter restarts.

## Timing
- Reset (rst_n=0 at edge):
  - State IDLE.
  - frame_data=0, frame_len=0, frame_valid=0, busy=0, overflow=0, timeout=0, counter=0.
  - Applies from any state, including mid-SEND; frame_valid drops at that edge.
- All outputs are registered.
- Key latency: a strobe sampled at edge N is reflected in frame_data/frame_len after edge N.
- Enter sampled at edge N:
  - frame_valid=1 and busy=1 after edge N.
  - The earliest handshake is at edge N+1.
- Handshake:
  - frame_valid stays high and frame_data stable until the edge where frame_ready=1.
  - frame_valid=0 after that edge.
  - frame_ready while frame_valid=0 is ignored.
- Key strobe on the same edge as the handshake: dropped (state is still SEND at that edge).
- overflow and timeout are exactly one cycle wide, asserted the cycle after the triggering edge.
- Back-to-back key_valid on consecutive cycles: each strobe is processed independently.

## Test plan
- Reset, keys 1,2,3, enter, frame_ready held 1:
  - frame_valid high for exactly one cycle with frame_data[11:0]=12'h123, frame_len=3.
  - Then IDLE with len=0.
- DEPTH=4, keys 9,8,7,6,5:
  - overflow pulses once on the fifth key.
  - frame_data=16'h9876, len=4.
- Keys 4,5, backspace, backspace, backspace, then enter:
  - len goes 1, 2, 1, 0, 0; data=0.
  - Enter is ignored and frame_valid never rises.
- Keys 1, enter, frame_ready=0 for 10 cycles, keys 2 and 3 during the stall, then frame_ready=1:
  - frame_data holds 4'h1 and len 1 throughout the stall.
  - The stall keys have no effect.
  - IDLE after the handshake.
- TIMEOUT=8, key 7 then no keys:
  - timeout pulses 8 cycles after the key; len=0.
  - Repeat with key C at cycle 5: the timeout time is unchanged.
  - Repeat with key 3 at cycle 5: the timeout moves to cycle 13 after the first key.
- Keys 1,2, enter, rst_n=0 during SEND:
  - After the reset edge, all outputs are 0 and the state is IDLE.
